// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^WIDTH) multiplier family.
//   gf_state_t  : control states of the iterative multiplier (IDLE/RUN/DONE)
//   GF_AES_POLY : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   GF16_POLY   : low nibble of the GF(16) polynomial x^4+x+1
//   gf_xtime    : multiply a field element by x, reducing by poly
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_t;

  localparam logic [7:0] GF_AES_POLY = 8'h1B;
  localparam logic [3:0] GF16_POLY   = 4'h3;

  // Widest field any instance may use; gf_xtime works at this width and
  // masks down to the field width it is given.
  localparam int GF_MAX_WIDTH = 16;

  // Multiply by x in GF(2^width): shift left, drop the bit leaving the field,
  // and fold it back in through the reduction polynomial.
  function automatic logic [GF_MAX_WIDTH-1:0] gf_xtime(
      input logic [GF_MAX_WIDTH-1:0] value,
      input logic [GF_MAX_WIDTH-1:0] poly,
      input int unsigned             width);
    logic [GF_MAX_WIDTH-1:0] mask;
    logic                    carry;
    // 17-bit intermediate so that width=16 yields an all-ones mask.
    mask  = GF_MAX_WIDTH'((17'(1) << width) - 17'(1));
    carry = value[width-1];
    gf_xtime = ((value << 1) & mask) ^ (carry ? (poly & mask) : '0);
  endfunction

endpackage

// File: rtl/gf_digit_step.sv
// Combinational digit of the shift-and-add GF multiplier.
// Performs DIGIT chained elementary steps on the working registers.
//   a_cur/b_cur/acc_cur    : multiplicand, remaining multiplier, accumulator
//   a_next/b_next/acc_next : the same three values after DIGIT steps
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_AES_POLY),
  parameter int               DIGIT = 1
) (
  input  logic [WIDTH-1:0] a_cur,
  input  logic [WIDTH-1:0] b_cur,
  input  logic [WIDTH-1:0] acc_cur,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] a_v;
  logic [WIDTH-1:0] b_v;
  logic [WIDTH-1:0] acc_v;

  // Each step consumes the multiplier LSB: add the current multiple of the
  // multiplicand, then advance the multiplicand to the next power of x.
  always_comb begin
    a_v   = a_cur;
    b_v   = b_cur;
    acc_v = acc_cur;
    for (int i = 0; i < DIGIT; i++) begin
      if (b_v[0]) begin
        acc_v = acc_v ^ a_v;
      end
      a_v = WIDTH'(gf_xtime(GF_MAX_WIDTH'(a_v), GF_MAX_WIDTH'(POLY), WIDTH));
      b_v = b_v >> 1;
    end
  end

  assign a_next   = a_v;
  assign b_next   = b_v;
  assign acc_next = acc_v;

endmodule

// File: rtl/gf_poly_multiplier.sv
// Iterative GF(2^WIDTH) multiplier: result = a*b mod (x^WIDTH + POLY).
// Consumes DIGIT multiplier bits per RUN cycle; with EARLY_EXIT it stops as
// soon as the remaining multiplier bits are zero.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready, a, b : operand handshake (accepted only in IDLE)
//   out_valid/out_ready, result : result handshake (held in DONE)
//   busy                 : high while in RUN or DONE
module gf_poly_multiplier
  import gf_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(GF_AES_POLY),
  parameter int               DIGIT      = 1,
  parameter bit               EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int STEPS = WIDTH / DIGIT;
  // One spare count keeps the counter at least one bit wide when STEPS=1.
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  // Catch illegal parameter combinations at elaboration.
  if (WIDTH < 2 || WIDTH > GF_MAX_WIDTH || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("gf_poly_multiplier: unsupported WIDTH/DIGIT combination");
  end

  gf_state_t        state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] b_step;
  logic [WIDTH-1:0] acc_step;

  gf_digit_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .DIGIT (DIGIT)
  ) u_digit_step (
    .a_cur    (a_reg),
    .b_cur    (b_reg),
    .acc_cur  (acc_reg),
    .a_next   (a_step),
    .b_next   (b_step),
    .acc_next (acc_step)
  );

  // Control FSM and datapath registers. All handshake outputs are
  // registered; in_ready is raised on the same edge that enters IDLE from
  // DONE so the next operand can be taken one cycle after the result leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            acc_reg  <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          a_reg   <= a_step;
          b_reg   <= b_step;
          acc_reg <= acc_step;
          cnt     <= cnt + 1'b1;
          // Once no multiplier bits remain, further steps cannot change ACC.
          if (cnt == LAST_CNT || (EARLY_EXIT && b_step == '0)) begin
            out_valid <= 1'b1;
            result    <= acc_step;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          result    <= '0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_poly_multiplier.sv
// Self-checking bench for gf_poly_multiplier. Three instances cover the AES
// field bit-serial, the GF(16) field, and the AES field with 2-bit digits and
// early exit. Expected results go into a scoreboard queue on accept and are
// popped when the selected instance raises out_valid.
module tb_gf_poly_multiplier;
  import gf_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic       in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [7:0] a0, b0, result0;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [3:0] a1, b1, result1;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [7:0] a2, b2, result2;

  int num_checks = 0;
  int num_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  gf_poly_multiplier #(.WIDTH(8), .POLY(GF_AES_POLY), .DIGIT(1), .EARLY_EXIT(1'b0)) u_aes (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .result(result0), .busy(busy0));

  gf_poly_multiplier #(.WIDTH(4), .POLY(GF16_POLY), .DIGIT(1), .EARLY_EXIT(1'b0)) u_gf16 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1), .busy(busy1));

  gf_poly_multiplier #(.WIDTH(8), .POLY(GF_AES_POLY), .DIGIT(2), .EARLY_EXIT(1'b1)) u_aes_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .busy(busy2));

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Bit-serial reference multiply in GF(2^w) with polynomial x^w + poly.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                         input int w, input logic [7:0] poly);
    logic [7:0] p, aa, msk;
    p   = '0;
    aa  = x;
    msk = 8'((9'(1) << w) - 9'(1));
    for (int i = 0; i < w; i++) begin
      if (y[i]) p = p ^ aa;
      if (aa[w-1]) aa = ((aa << 1) & msk) ^ poly;
      else         aa = (aa << 1) & msk;
    end
    return p;
  endfunction

  // RUN cycles for the early-exit, 2-bit-digit instance.
  function automatic int runs_early(input logic [7:0] y, input int digit);
    int msb;
    msb = -1;
    for (int i = 0; i < 8; i++) if (y[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + digit) / digit;
  endfunction

  task automatic set_inputs(input int sel, input logic v, input logic [7:0] av, input logic [7:0] bv);
    case (sel)
      0: begin in_valid0 = v; a0 = av;      b0 = bv;      end
      1: begin in_valid1 = v; a1 = av[3:0]; b1 = bv[3:0]; end
      default: begin in_valid2 = v; a2 = av; b2 = bv; end
    endcase
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    case (sel)
      0: out_ready0 = v;
      1: out_ready1 = v;
      default: out_ready2 = v;
    endcase
  endtask

  function automatic logic get_in_ready(input int sel);
    case (sel) 0: return in_ready0; 1: return in_ready1; default: return in_ready2; endcase
  endfunction

  function automatic logic get_out_valid(input int sel);
    case (sel) 0: return out_valid0; 1: return out_valid1; default: return out_valid2; endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction

  function automatic logic [7:0] get_result(input int sel);
    case (sel) 0: return result0; 1: return {4'b0, result1}; default: return result2; endcase
  endfunction

  // One full operation: accept, count RUN cycles while scrambling the inputs,
  // hold DONE for 'hold' cycles, then complete the result handshake.
  task automatic apply_stimulus(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                input logic [7:0] expv, input int exp_n, input int hold);
    int n;
    int waited;
    bit seen;
    logic [7:0] sb;
    waited = 0;
    while (!get_in_ready(sel) && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check_output($sformatf("in_ready_idle_s%0d", sel), 32'(get_in_ready(sel)), 32'd1);
    @(negedge clk);
    set_inputs(sel, 1'b1, av, bv);
    @(posedge clk); #1;
    exp_q.push_back(expv);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      set_inputs(sel, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      n++;
      if (get_out_valid(sel)) seen = 1;
      else check_output($sformatf("in_ready_run_s%0d", sel), 32'(get_in_ready(sel)), 32'd0);
    end
    check_output($sformatf("latency_s%0d_%h_%h", sel, av, bv), 32'(n), 32'(exp_n));
    sb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_output($sformatf("result_s%0d_%h_%h", sel, av, bv), 32'(get_result(sel)), 32'(sb));
    check_output($sformatf("busy_done_s%0d", sel), 32'(get_busy(sel)), 32'd1);
    for (int h = 0; h < hold; h++) begin
      set_inputs(sel, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      check_output($sformatf("hold_valid_s%0d", sel), 32'(get_out_valid(sel)), 32'd1);
      check_output($sformatf("hold_result_s%0d", sel), 32'(get_result(sel)), 32'(sb));
      check_output($sformatf("hold_in_ready_s%0d", sel), 32'(get_in_ready(sel)), 32'd0);
    end
    set_inputs(sel, 1'b0, 8'h00, 8'h00);
    set_out_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_out_ready(sel, 1'b0);
    check_output($sformatf("post_valid_s%0d", sel), 32'(get_out_valid(sel)), 32'd0);
    check_output($sformatf("post_result_s%0d", sel), 32'(get_result(sel)), 32'd0);
    check_output($sformatf("post_in_ready_s%0d", sel), 32'(get_in_ready(sel)), 32'd1);
    check_output($sformatf("post_busy_s%0d", sel), 32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    logic [7:0] ra, rb;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      set_inputs(s, 1'b0, 8'h00, 8'h00);
      set_out_ready(s, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_output($sformatf("rst_in_ready_s%0d", s), 32'(get_in_ready(s)), 32'd0);
      check_output($sformatf("rst_out_valid_s%0d", s), 32'(get_out_valid(s)), 32'd0);
      check_output($sformatf("rst_result_s%0d", s), 32'(get_result(s)), 32'd0);
      check_output($sformatf("rst_busy_s%0d", s), 32'(get_busy(s)), 32'd0);
    end
    rst = 1'b0;

    // AES field, bit-serial; first op also exercises DONE backpressure.
    apply_stimulus(0, 8'h57, 8'h83, 8'hC1, 8, 5);
    apply_stimulus(0, 8'h57, 8'h13, 8'hFE, 8, 0);
    apply_stimulus(0, 8'h00, 8'hFF, 8'h00, 8, 0);

    // GF(16): known vector, then all operand pairs against the model.
    apply_stimulus(1, 8'h07, 8'h0B, 8'h04, 4, 0);
    for (int i = 0; i < 256; i++) begin
      ra = 8'(i % 16);
      rb = 8'(i / 16);
      apply_stimulus(1, ra, rb, ref_mul(ra, rb, 4, 8'(GF16_POLY)), 4, 0);
    end

    // AES field, 2-bit digits with early exit.
    apply_stimulus(2, 8'hFF, 8'h00, 8'h00, 1, 0);
    apply_stimulus(2, 8'h57, 8'h03, 8'hF9, 1, 0);
    apply_stimulus(2, 8'h57, 8'h80, ref_mul(8'h57, 8'h80, 8, GF_AES_POLY), 4, 2);
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      apply_stimulus(2, ra, rb, ref_mul(ra, rb, 8, GF_AES_POLY), runs_early(rb, 2), 0);
    end

    // Reset during the third RUN cycle discards the operation.
    @(negedge clk);
    set_inputs(0, 1'b1, 8'h57, 8'h83);
    @(posedge clk); #1;
    set_inputs(0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_output("mid_run_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("mid_rst_out_valid", 32'(out_valid0), 32'd0);
    check_output("mid_rst_busy", 32'(busy0), 32'd0);
    check_output("mid_rst_result", 32'(result0), 32'd0);
    check_output("mid_rst_in_ready", 32'(in_ready0), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1;
    end
    check_output("mid_rst_no_output", 32'(seen), 32'd0);
    apply_stimulus(0, 8'h02, 8'h87, 8'h15, 8, 0);

    // Reset together with in_valid: nothing is captured.
    @(negedge clk);
    set_inputs(2, 1'b1, 8'h57, 8'h83);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_inputs(2, 1'b0, 8'h00, 8'h00);
    check_output("rst_wins_busy", 32'(busy2), 32'd0);
    check_output("rst_wins_in_ready", 32'(in_ready2), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_wins_idle_busy", 32'(busy2), 32'd0);
    apply_stimulus(2, 8'h02, 8'h87, 8'h15, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_errors);
    $finish;
  end

endmodule
